// File: rtl/hydra_pkg.sv
// Shared constants and state type for the Hydra strand output path.
// All timing constants are in 50 MHz system clocks.
package hydra_pkg;

  localparam int unsigned MEM_DATA_WIDTH     = 24;
  localparam int unsigned STRAND_PARAM_WIDTH = 16;
  localparam int unsigned CLK_HZ             = 50_000_000;

  // WS2811 single-wire bit timing
  localparam int unsigned T0H  = 20;
  localparam int unsigned T1H  = 40;
  localparam int unsigned TBIT = 62;

  // WS2801 runs one data cycle plus one clock-high cycle per bit
  localparam int unsigned WS2801_TBIT = 2;

  localparam int unsigned WS2801_LATCH = 25000;
  localparam int unsigned WS2811_LATCH = 2500;

  localparam int unsigned BIT_CNT_W   = 6;
  localparam int unsigned BITN_W      = $clog2(MEM_DATA_WIDTH);
  localparam int unsigned LATCH_CNT_W = 15;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StShift,
    StLatch,
    StDone
  } strand_state_e;

endpackage

// File: rtl/strand_bit_encoder.sv
// Encodes one bit onto the strand pins in WS2801 (clock + data) or WS2811 (NRZ) form.
// A start pulse loads the bit; bit_done_o marks the final cycle of the bit period.
module strand_bit_encoder
  import hydra_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic bit_i,
  input  logic mode_i,
  output logic strand_clk_o,
  output logic strand_data_o,
  output logic bit_done_o
);

  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0] last_cnt, high_cnt;
  logic                 bit_q, bit_d;
  logic                 active_q, active_d;
  logic                 clk_d, data_d;

  assign last_cnt   = mode_i ? BIT_CNT_W'(TBIT - 1) : BIT_CNT_W'(WS2801_TBIT - 1);
  assign bit_done_o = active_q && (cnt_q == last_cnt);

  // Outputs are computed from next state so a start pulse shows on the pins at the same edge
  always_comb begin
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (start_i) begin
      cnt_d    = '0;
      bit_d    = bit_i;
      active_d = 1'b1;
    end else if (bit_done_o) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q + BIT_CNT_W'(1);
    end
    high_cnt = bit_d ? BIT_CNT_W'(T1H) : BIT_CNT_W'(T0H);
    clk_d    = active_d && !mode_i && (cnt_d == BIT_CNT_W'(1));
    data_d   = active_d && (mode_i ? (cnt_d < high_cnt) : bit_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      bit_q         <= 1'b0;
      active_q      <= 1'b0;
      strand_clk_o  <= 1'b0;
      strand_data_o <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      active_q      <= active_d;
      strand_clk_o  <= clk_d;
      strand_data_o <= data_d;
    end
  end

endmodule

// File: rtl/strand_driver.sv
// Frame engine: walks the frame buffer, prefetching one pixel ahead, and streams
// each 24-bit word MSB-first through the bit encoder, then holds the latch gap.
module strand_driver
  import hydra_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ws2811_mode,
  input  logic [STRAND_PARAM_WIDTH-1:0] strand_length,
  output logic [STRAND_PARAM_WIDTH-1:0] current_idx,
  input  logic [MEM_DATA_WIDTH-1:0]     mem_data,
  input  logic                          start_frame,
  output logic                          busy,
  output logic                          done,
  output logic                          strand_clk,
  output logic                          strand_data
);

  strand_state_e                 state_q;
  logic                          mode_q, fetch_q, busy_q, done_q;
  logic [STRAND_PARAM_WIDTH-1:0] len_q, idx_q, pix_q;
  logic [MEM_DATA_WIDTH-1:0]     shreg_q;
  logic [BITN_W-1:0]             bitn_q;
  logic [LATCH_CNT_W-1:0]        latch_q, latch_last;

  logic [STRAND_PARAM_WIDTH:0] pix_next, idx_next, len_ext;
  logic last_bit, more_pix, idx_adv;
  logic load_first, reload, advance;
  logic enc_start, enc_bit, enc_bit_done;

  assign len_ext    = {1'b0, len_q};
  assign pix_next   = {1'b0, pix_q} + (STRAND_PARAM_WIDTH + 1)'(1);
  assign idx_next   = {1'b0, idx_q} + (STRAND_PARAM_WIDTH + 1)'(1);
  assign more_pix   = pix_next < len_ext;
  assign idx_adv    = idx_next < len_ext;
  assign last_bit   = bitn_q == BITN_W'(MEM_DATA_WIDTH - 1);
  assign latch_last = mode_q ? LATCH_CNT_W'(WS2811_LATCH - 1) : LATCH_CNT_W'(WS2801_LATCH - 1);

  assign load_first = (state_q == StFetch) && fetch_q;
  assign reload     = (state_q == StShift) && enc_bit_done && last_bit && more_pix;
  assign advance    = (state_q == StShift) && enc_bit_done && !last_bit;
  assign enc_start  = load_first || reload || advance;
  assign enc_bit    = (load_first || reload) ? mem_data[MEM_DATA_WIDTH-1]
                                             : shreg_q[MEM_DATA_WIDTH-2];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      fetch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      pix_q   <= '0;
      shreg_q <= '0;
      bitn_q  <= '0;
      latch_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          idx_q <= '0;
          if (start_frame) begin
            mode_q  <= ws2811_mode;
            len_q   <= strand_length;
            busy_q  <= 1'b1;
            fetch_q <= 1'b0;
            if (strand_length == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StFetch: begin
          if (!fetch_q) begin
            fetch_q <= 1'b1;
          end else begin
            shreg_q <= mem_data;
            bitn_q  <= '0;
            pix_q   <= '0;
            if (idx_adv) idx_q <= idx_q + STRAND_PARAM_WIDTH'(1);
            state_q <= StShift;
          end
        end
        StShift: begin
          if (enc_bit_done) begin
            if (!last_bit) begin
              shreg_q <= shreg_q << 1;
              bitn_q  <= bitn_q + BITN_W'(1);
            end else if (more_pix) begin
              shreg_q <= mem_data;
              bitn_q  <= '0;
              pix_q   <= pix_q + STRAND_PARAM_WIDTH'(1);
              if (idx_adv) idx_q <= idx_q + STRAND_PARAM_WIDTH'(1);
            end else begin
              latch_q <= '0;
              state_q <= StLatch;
            end
          end
        end
        StLatch: begin
          if (latch_q == latch_last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            latch_q <= latch_q + LATCH_CNT_W'(1);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  strand_bit_encoder u_enc (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .start_i      (enc_start),
    .bit_i        (enc_bit),
    .mode_i       (mode_q),
    .strand_clk_o (strand_clk),
    .strand_data_o(strand_data),
    .bit_done_o   (enc_bit_done)
  );

  assign current_idx = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_strand_driver.sv
// Scoreboard bench for strand_driver: stimulus queues expected words and latencies,
// a monitor decodes the strand pins and checks them as they appear.
module tb_strand_driver;

  logic        clk, rst_n, ws2811_mode, start_frame;
  logic [15:0] strand_length, current_idx;
  logic [23:0] mem_data;
  logic        busy, done, strand_clk, strand_data;

  logic [23:0] ram [256];
  logic [23:0] exp_words[$];
  int          exp_lat[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int accept_cyc, rise_cnt, hi_cnt, done_cnt, max_idx;
  logic [15:0] prev_idx;
  logic        cur_mode;

  strand_driver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ws2811_mode  (ws2811_mode),
    .strand_length(strand_length),
    .current_idx  (current_idx),
    .mem_data     (mem_data),
    .start_frame  (start_frame),
    .busy         (busy),
    .done         (done),
    .strand_clk   (strand_clk),
    .strand_data  (strand_data)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_data <= ram[current_idx[7:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decodes pins into words, checks addressing and done latency
  initial begin : monitor
    logic        prev_clk, prev_data, b;
    logic [23:0] word, expw;
    int          nbits, hi_start, w, ptime, expl;
    prev_clk = 0; prev_data = 0; nbits = 0; hi_start = 0; word = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        nbits = 0; prev_clk = 0; prev_data = 0;
      end else begin
        ptime = cur_mode ? 1488 : 48;
        if (strand_clk && !prev_clk) begin
          rise_cnt++;
          if (!cur_mode) begin
            word = {word[22:0], strand_data};
            nbits++;
          end
        end
        if (strand_data && !prev_data) begin
          hi_cnt++;
          hi_start = cyc;
        end
        if (!strand_data && prev_data && cur_mode) begin
          w = cyc - hi_start;
          b = (w == 40) ? 1'b1 : (w == 20) ? 1'b0 : 1'bx;
          word = {word[22:0], b};
          nbits++;
        end
        if (nbits == 24) begin
          nbits = 0;
          if (exp_words.size() == 0) begin
            check("unexpected_word", word, 24'h0 ^ 24'hFFFFFF ^ word ^ 24'h1);
          end else begin
            expw = exp_words.pop_front();
            check("pixel_word", word, expw);
          end
        end
        if (busy && current_idx !== prev_idx) begin
          check("idx_step", current_idx, prev_idx + 16'd1);
          check("idx_time", cyc - accept_cyc, 2 + ptime * int'(prev_idx));
          prev_idx = current_idx;
          if (int'(current_idx) > max_idx) max_idx = int'(current_idx);
        end
        if (done) begin
          done_cnt++;
          if (exp_lat.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            expl = exp_lat.pop_front();
            check("done_latency", cyc - accept_cyc, expl);
          end
        end
        prev_clk  = strand_clk;
        prev_data = strand_data;
      end
    end
  end

  task automatic start(input logic mode, input int len);
    @(negedge clk);
    ws2811_mode   = mode;
    strand_length = 16'(len);
    start_frame   = 1'b1;
    cur_mode      = mode;
    prev_idx      = '0;
    max_idx       = 0;
    rise_cnt      = 0;
    hi_cnt        = 0;
    accept_cyc    = cyc + 1;
    for (int i = 0; i < len; i++) exp_words.push_back(ram[i]);
    exp_lat.push_back(len == 0 ? 0 : 2 + len * (mode ? 1488 : 48) + (mode ? 2500 : 25000));
    @(negedge clk);
    start_frame = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("frame_timeout", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("words_left", exp_words.size(), 0);
    check("lat_left", exp_lat.size(), 0);
  endtask

  initial begin
    rst_n = 1'b1; ws2811_mode = 1'b0; start_frame = 1'b0; strand_length = '0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    done_cnt = 0; rise_cnt = 0; hi_cnt = 0; max_idx = 0; prev_idx = '0; cur_mode = 1'b0;
    accept_cyc = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {current_idx, busy, done, strand_clk, strand_data}, 20'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // WS2801, 160 pixels of a constant word
    for (int i = 0; i < 256; i++) ram[i] = 24'hACE1AE;
    start(1'b0, 160);
    check("busy_after_accept", busy, 1'b1);
    wait_idle(33000);
    check("ws2801_clk_edges", rise_cnt, 3840);
    check("ws2801_max_idx", max_idx, 159);

    // WS2801 addressing with a RAM that returns its index; mid-frame restart ignored
    for (int i = 0; i < 256; i++) ram[i] = 24'(i);
    start(1'b0, 5);
    repeat (60) @(negedge clk);
    ws2811_mode = 1'b1; strand_length = 16'd3; start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    wait_idle(25300);
    check("addr_max_idx", max_idx, 4);
    check("addr_clk_edges", rise_cnt, 120);

    // WS2811, two words
    ram[0] = 24'hFF0000; ram[1] = 24'h00000F;
    start(1'b1, 2);
    wait_idle(5600);
    check("ws2811_clk_low", rise_cnt, 0);
    check("ws2811_high_pulses", hi_cnt, 48);

    // length 0
    start(1'b0, 0);
    check("len0_busy", busy, 1'b1);
    check("len0_done", done, 1'b1);
    @(negedge clk);
    check("len0_idle", {busy, done}, 2'b00);
    wait_idle(10);
    check("len0_no_activity", rise_cnt + hi_cnt, 0);

    // Reset during SHIFT aborts without done, then a length-1 WS2811 frame runs
    start(1'b0, 10);
    repeat (100) @(negedge clk);
    begin
      int d0;
      d0 = done_cnt;
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1 check("abort_outputs", {current_idx, busy, done, strand_clk, strand_data}, 20'h0);
      exp_words.delete();
      exp_lat.delete();
      repeat (30) @(negedge clk);
      check("abort_no_done", done_cnt, d0);
      rst_n = 1'b0;
      @(negedge clk);
    end
    ram[0] = 24'h5A00C3;
    start(1'b1, 1);
    check("len1_idx", current_idx, 16'd0);
    wait_idle(4100);
    check("len1_max_idx", max_idx, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/strand_driver.md
# strand_driver

Serial pixel-strand output engine for the Hydra lighting controller. On a `start_frame` strobe it walks pixel addresses 0..`strand_length`-1, fetches each 24-bit colour word from the frame buffer, and shifts it out MSB-first. Two line encodings are supported: WS2801 (separate clock and data lines) and WS2811 (single-wire NRZ pulse-width encoding). After the last pixel it holds the latch gap, then reports completion. It sits between the frame-buffer RAM read port and the strand output pins.

## Interface
- `MEM_DATA_WIDTH`, 24, bits per pixel word, shifted MSB-first.
- `STRAND_PARAM_WIDTH`, 16, width of the length and index fields.
- `clk`  in  1  system clock, 50 MHz; all timing constants assume 20 ns.
- `rst_n`  in  1  one clock; reset is asynchronous and active-high. The port keeps the codebase name `rst_n`, but it is asserted when 1.
- `ws2811_mode`  in  1  encoding select: 1 = WS2811, 0 = WS2801. Sampled on an accepted `start_frame`.
- `strand_length`  in  16  number of pixels. Sampled on an accepted `start_frame`.
- `current_idx`  out  16  frame-buffer read address.
- `mem_data`  in  24  read data. Valid 1 cycle after `current_idx` changes (synchronous RAM).
- `start_frame`  in  1  start strobe. Accepted only when `busy`=0.
- `busy`  out  1  high while a frame, including its latch gap, is in progress.
- `done`  out  1  one-cycle pulse at frame end.
- `strand_clk`  out  1  WS2801 clock. Held 0 in WS2811 mode.
- `strand_data`  out  1  serial data.

## Operation
- States: IDLE, FETCH, SHIFT, LATCH, DONE.
- IDLE:
  - `current_idx`=0.
  - On `start_frame`=1: capture mode and length.
  - If length=0: go to DONE.
  - Otherwise: go to FETCH.
- FETCH (2 cycles):
  - Load `mem_data` (address 0) into a 24-bit shift register.
  - Set `current_idx`=1 if length>1.
  - Go to SHIFT.
- SHIFT: emit 24 bits, MSB first.
- Prefetch: after each pixel load, `current_idx` advances to the next pixel. It never exceeds length-1.
- At the last-bit boundary:
  - If pixels remain: reload the shift register from `mem_data` with no gap between pixels.
  - Otherwise: go to LATCH.
- WS2801 bit encoding, 2 clk per bit (25 MHz):
  - `strand_clk`=0 with `strand_data`=bit for 1 cycle.
  - Then `strand_clk`=1 for 1 cycle; the strand samples on the rising edge.
- WS2811 bit encoding, 62 clk per bit:
  - `strand_data`=1 for T0H=20 clk (bit 0) or T1H=40 clk (bit 1).
  - `strand_data`=0 for the rest of the bit period.
- LATCH:
  - Both outputs held 0.
  - Duration is 25000 clk (500 µs) for WS2801 or 2500 clk (50 µs) for WS2811.
  - Then go to DONE.
- DONE (1 cycle):
  - `done`=1, then return to IDLE.
  - `busy` falls on the same edge that `done` falls.
- `start_frame` while busy is ignored. Input changes mid-frame have no effect.

## Timing
- Reset values: `current_idx`=0, `busy`=0, `done`=0, `strand_clk`=0, `strand_data`=0. State=IDLE, all counters 0.
- Reset asserted mid-frame aborts immediately to the reset values. No `done` pulse is produced.
- Accept edge E:
  - `busy`=1 from E.
  - `mem_data` for index 0 is sampled at E+2.
  - First bit is driven from E+2.
- Per-pixel time: 48 clk (WS2801) or 1488 clk (WS2811).
- Frame latency from E to `done` = 2 + N·(48 or 1488) + (25000 or 2500) cycles.
  - Example: N=160, WS2801 → 32682 cycles.
- length=1: `current_idx` stays 0 throughout.
- length=0: `busy` for exactly 1 cycle, then `done` pulses. No line activity.

## Structure
- Shared package `hydra_pkg` holds:
  - `MEM_DATA_WIDTH`, `STRAND_PARAM_WIDTH`.
  - `CLK_HZ`.
  - WS2811 timing constants: `T0H`, `T1H`, `TBIT`.
  - Latch constants: `WS2801_LATCH`, `WS2811_LATCH`.
  - The state enum.
- One sub-module: `strand_bit_encoder`.
  - Takes a bit, a mode and a start pulse.
  - Produces `strand_clk`/`strand_data` and a `bit_done` strobe.
  - Owns the per-bit timing counter.

## Test plan
- Reset, then WS2801, length=160, `mem_data`=24'hACE1AE (constant):
  - 3840 rising `strand_clk` edges.
  - `strand_data` at each edge repeats the pattern 101011001110000110101110.
  - `done` at cycle E+32682.
- WS2811, length=2, words 24'hFF0000 / 24'h00000F:
  - First 8 bits have 40-clk highs; remaining bits have 20-clk highs, except the last 4 bits, which have 40-clk highs.
  - `strand_clk` stays 0.
  - `done` at E+2+2976+2500.
- length=0 → `busy` for 1 cycle, `done` pulses, outputs stay 0.
- `start_frame` pulsed again mid-frame → ignored; frame length unchanged.
- Reset asserted during SHIFT → all outputs 0 immediately, no `done`. A new `start_frame` after release runs a full frame.
- Addressing: `current_idx` sequence 0,1,…,N-1, each value held for one pixel time. RAM model returns the index as data; verify the shifted words match the index sequence.
